// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
// Registers the decode bus under stall control, selects the ALU operands,
// computes the one-hot ALU result and issues the data SRAM request.
// All outputs are combinational from the single pipeline register.
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int STALL_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [37:0]             ex_to_id_forwarding,
  output logic                    ex_is_load,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  localparam logic STOP = 1'b1;

  logic [ID_TO_EX_WD-1:0] id_to_ex_bus_d, id_to_ex_bus_q;

  // Field views of the registered decode bus
  logic [31:0] pc_q, inst_q, rs_val_q, rt_val_q;
  logic [11:0] alu_op_q;
  logic [2:0]  sel_src1_q;
  logic [3:0]  sel_src2_q;
  logic        ram_en_q, rf_we_q, sel_rf_res_q;
  logic [3:0]  ram_wen_q;
  logic [4:0]  rf_waddr_q;

  assign pc_q         = id_to_ex_bus_q[158:127];
  assign inst_q       = id_to_ex_bus_q[126:95];
  assign alu_op_q     = id_to_ex_bus_q[94:83];
  assign sel_src1_q   = id_to_ex_bus_q[82:80];
  assign sel_src2_q   = id_to_ex_bus_q[79:76];
  assign ram_en_q     = id_to_ex_bus_q[75];
  assign ram_wen_q    = id_to_ex_bus_q[74:71];
  assign rf_we_q      = id_to_ex_bus_q[70];
  assign rf_waddr_q   = id_to_ex_bus_q[69:65];
  assign sel_rf_res_q = id_to_ex_bus_q[64];
  assign rs_val_q     = id_to_ex_bus_q[63:32];
  assign rt_val_q     = id_to_ex_bus_q[31:0];

  // Bits of the instruction word and stall vector this stage never looks at
  logic unused_bits;
  assign unused_bits = ^{inst_q[31:16], inst_q[5:0], stall[STALL_W-1:4], stall[1:0]};

  // Next register value: bubble when ID stops but EX moves, load when ID moves, else hold
  always_comb begin
    id_to_ex_bus_d = id_to_ex_bus_q;
    if (stall[2] == STOP && stall[3] != STOP) begin
      id_to_ex_bus_d = '0;
    end else if (stall[2] != STOP) begin
      id_to_ex_bus_d = id_to_ex_bus;
    end
  end

  // Pipeline register; reset yields a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      id_to_ex_bus_q <= '0;
    end else begin
      id_to_ex_bus_q <= id_to_ex_bus_d;
    end
  end

  // Operand select: one-hot masks ORed, so an empty select gives 0
  logic [31:0] src1, src2, imm_sext, imm_zext, sa_zext;
  assign imm_sext = {{16{inst_q[15]}}, inst_q[15:0]};
  assign imm_zext = {16'b0, inst_q[15:0]};
  assign sa_zext  = {27'b0, inst_q[10:6]};

  always_comb begin
    src1 = ({32{sel_src1_q[0]}} & rs_val_q)
         | ({32{sel_src1_q[1]}} & pc_q)
         | ({32{sel_src1_q[2]}} & sa_zext);
    src2 = ({32{sel_src2_q[0]}} & rt_val_q)
         | ({32{sel_src2_q[1]}} & imm_sext)
         | ({32{sel_src2_q[2]}} & 32'd8)
         | ({32{sel_src2_q[3]}} & imm_zext);
  end

  // ALU: every op computed in parallel, the one-hot op mask picks the result
  logic signed [31:0] src1_s, src2_s, sra_s;
  logic [31:0] res_add, res_sub, res_slt, res_sltu, res_and, res_nor;
  logic [31:0] res_or, res_xor, res_sll, res_srl, res_sra, res_lui;
  logic [31:0] ex_result;
  logic [4:0]  shamt;

  assign src1_s = src1;
  assign src2_s = src2;
  assign shamt  = src1[4:0];
  assign sra_s  = src2_s >>> shamt;

  always_comb begin
    res_add  = src1 + src2;
    res_sub  = src1 - src2;
    res_slt  = {31'b0, (src1_s < src2_s)};
    res_sltu = {31'b0, (src1 < src2)};
    res_and  = src1 & src2;
    res_nor  = ~(src1 | src2);
    res_or   = src1 | src2;
    res_xor  = src1 ^ src2;
    res_sll  = src2 << shamt;
    res_srl  = src2 >> shamt;
    res_sra  = sra_s;
    res_lui  = {src2[15:0], 16'b0};
    ex_result = ({32{alu_op_q[11]}} & res_add)
              | ({32{alu_op_q[10]}} & res_sub)
              | ({32{alu_op_q[9]}}  & res_slt)
              | ({32{alu_op_q[8]}}  & res_sltu)
              | ({32{alu_op_q[7]}}  & res_and)
              | ({32{alu_op_q[6]}}  & res_nor)
              | ({32{alu_op_q[5]}}  & res_or)
              | ({32{alu_op_q[4]}}  & res_xor)
              | ({32{alu_op_q[3]}}  & res_sll)
              | ({32{alu_op_q[2]}}  & res_srl)
              | ({32{alu_op_q[1]}}  & res_sra)
              | ({32{alu_op_q[0]}}  & res_lui);
  end

  // Memory request, downstream bus and forwarding to decode
  always_comb begin
    data_sram_en    = ram_en_q;
    data_sram_wen   = ram_en_q ? ram_wen_q : 4'b0;
    data_sram_addr  = ex_result;
    data_sram_wdata = rt_val_q;
    ex_to_mem_bus   = {pc_q, ram_en_q, ram_wen_q, sel_rf_res_q, rf_we_q, rf_waddr_q, ex_result};
    // Load data only exists after MEM, so a load never forwards from here
    ex_to_id_forwarding = {rf_we_q & ~sel_rf_res_q, rf_waddr_q, ex_result};
    ex_is_load      = ram_en_q & ~(|ram_wen_q) & sel_rf_res_q;
  end

endmodule
